// File: rtl/expu_res_collector.sv
// -----------------------------------------------------------------------------
// expu_res_collector_pkg
//   Minimal floating-point format description for the collector. The format
//   encoding and widths follow the fpnew convention, so the FPFORMAT parameter
//   can be passed straight through from an fpnew-based exp unit.
// -----------------------------------------------------------------------------
package expu_res_collector_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 16;
        endcase
    endfunction

endpackage

// -----------------------------------------------------------------------------
// expu_res_collector
//   Receive side of the exponential-unit datapath. Results leaving the exp
//   row pipeline (LATENCY stages, advancing only on an accepted issue) are
//   re-associated with the row strobes of the beat they belong to, stored in a
//   fall-through result FIFO and handed downstream over valid/ready.
//
//   Because the exp pipeline only moves when a new beat is accepted, it cannot
//   be stalled at its output. Every non-bubble beat therefore reserves a FIFO
//   slot (a credit) at issue time; the credit comes back when the beat is
//   popped. Bubbles (all-zero strobe) take no credit and are never stored;
//   they exist only to push earlier items out of the pipeline.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   clear_i        synchronous clear, same effect as reset, highest priority
//   issue_valid_i  issuer presents a beat to the exp unit
//   issue_strb_i   row strobes of the issued beat (0 = bubble)
//   issue_ready_o  beat accepted; also drives the exp unit ready_i
//   exp_res_i      exp unit res_o (result of the item in its last stage)
//   valid_o        a result beat is available at the FIFO head
//   ready_i        downstream accepts the head beat
//   res_o          head beat results (0 when empty)
//   strb_o         head beat row strobes (0 when empty)
// -----------------------------------------------------------------------------
module expu_res_collector
    import expu_res_collector_pkg::*;
#(
    parameter fp_format_e  FPFORMAT = FP16ALT,
    parameter int unsigned N_ROWS   = 1,
    parameter int unsigned LATENCY  = 0,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned WIDTH   = fp_width(FPFORMAT)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    issue_valid_i,
    input  logic [N_ROWS-1:0]       issue_strb_i,
    output logic                    issue_ready_o,
    input  logic [N_ROWS*WIDTH-1:0] exp_res_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [N_ROWS*WIDTH-1:0] res_o,
    output logic [N_ROWS-1:0]       strb_o
);

    localparam int unsigned DW = N_ROWS * WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Tag array length; kept at 1 when LATENCY == 0 so the array is never empty.
    localparam int unsigned TL = (LATENCY > 0) ? LATENCY : 1;

    // An in-flight item's bookkeeping: does it own a credit, and its strobes.
    typedef struct packed {
        logic              valid;
        logic [N_ROWS-1:0] strb;
    } tag_t;

    typedef struct packed {
        logic [N_ROWS-1:0] strb;
        logic [DW-1:0]     data;
    } entry_t;

    // A FIFO shallower than the pipeline would let credits run out while
    // every credit-holding item is still stuck inside the pipeline.
    if (DEPTH < LATENCY + 1) begin : g_depth_check
        $error("expu_res_collector: DEPTH must be at least LATENCY+1");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CW-1:0] credits_q, credits_d;
    logic [CW-1:0] count_q,   count_d;
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic          wr_pending_q, wr_pending_d;
    tag_t          tags_q [TL];
    tag_t          tags_d [TL];
    entry_t        mem_q  [DEPTH];

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic   issue_fire;
    logic   take;
    logic   pop;
    logic   wr_en;
    entry_t wr_entry;
    tag_t   new_tag;

    // Depends on the credit register only, so no path from issue_valid_i or
    // ready_i reaches issue_ready_o.
    assign issue_ready_o = (credits_q != '0);
    assign issue_fire    = issue_valid_i & issue_ready_o;
    assign take          = issue_fire & (|issue_strb_i);

    assign valid_o = (count_q != '0);
    assign pop     = valid_o & ready_i;

    assign new_tag.valid = |issue_strb_i;
    assign new_tag.strb  = issue_strb_i;

    // -------------------------------------------------------------------------
    // Tag shift register mirroring the exp pipeline stages
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        tags_d       = tags_q;
        wr_pending_d = 1'b0;
        if (LATENCY > 0 && issue_fire) begin
            tags_d[0] = new_tag;
            for (int i = 1; i < TL; i++) begin
                tags_d[i] = tags_q[i-1];
            end
            // The last pipeline stage loads on this same edge; its result is
            // on exp_res_i during the following cycle.
            wr_pending_d = tags_d[TL-1].valid;
        end
    end

    // With no pipeline registers the exp result is combinational, so the item
    // is written in its own issue cycle. Otherwise it is written the cycle
    // after it reaches the last stage.
    assign wr_en         = (LATENCY == 0) ? take : wr_pending_q;
    assign wr_entry.strb = (LATENCY == 0) ? issue_strb_i : tags_q[TL-1].strb;
    assign wr_entry.data = exp_res_i;

    // -------------------------------------------------------------------------
    // Credit, occupancy and pointer next-state
    // -------------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        credits_d = credits_q;
        case ({take, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            credits_q    <= CW'(DEPTH);
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_pending_q <= 1'b0;
            for (int i = 0; i < TL; i++) begin
                tags_q[i] <= '0;
            end
        end else begin
            credits_q    <= credits_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_pending_q <= wr_pending_d;
            tags_q       <= tags_d;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, since valid_o is derived from the reset counter.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Fall-through head; outputs are forced to zero while empty.
    assign res_o  = valid_o ? mem_q[rd_ptr_q].data : '0;
    assign strb_o = valid_o ? mem_q[rd_ptr_q].strb : '0;

    // -------------------------------------------------------------------------
    // Protocol checks
    // -------------------------------------------------------------------------
    a_credit_max : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        credits_q <= CW'(DEPTH))
        else $error("expu_res_collector: credits exceed DEPTH");

    a_credit_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (take && !pop) |-> (credits_q != '0))
        else $error("expu_res_collector: credit underflow");

    a_credit_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (pop && !take) |-> (credits_q != CW'(DEPTH)))
        else $error("expu_res_collector: credit overflow");

    a_write_full : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        wr_en |-> ((count_q != CW'(DEPTH)) || pop))
        else $error("expu_res_collector: write into full FIFO");

endmodule

// File: tb/tb_expu_res_collector.sv
// -----------------------------------------------------------------------------
// tb_expu_res_collector
//   Two collectors side by side: u_a (LATENCY=0, DEPTH=4, one row) and
//   u_b (LATENCY=2, DEPTH=3, two rows). u_b runs a cycle-by-cycle vector
//   table; the remaining corner cases are short hand-written sequences.
//   Inputs change 1 time unit after the rising edge; outputs are sampled at
//   that same point, i.e. they show the state produced by the previous edge.
// -----------------------------------------------------------------------------
module tb_expu_res_collector;
    import expu_res_collector_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: LATENCY=0, DEPTH=4, N_ROWS=1
    logic        a_clear, a_iv, a_ir, a_ready, a_valid;
    logic [0:0]  a_strb, a_strb_o;
    logic [15:0] a_xres, a_res;

    // Instance B: LATENCY=2, DEPTH=3, N_ROWS=2
    logic        b_clear, b_iv, b_ir, b_ready, b_valid;
    logic [1:0]  b_strb, b_strb_o;
    logic [31:0] b_xres, b_res;

    expu_res_collector #(.FPFORMAT(FP16ALT), .N_ROWS(1), .LATENCY(0), .DEPTH(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear),
        .issue_valid_i(a_iv), .issue_strb_i(a_strb), .issue_ready_o(a_ir),
        .exp_res_i(a_xres), .valid_o(a_valid), .ready_i(a_ready),
        .res_o(a_res), .strb_o(a_strb_o)
    );

    expu_res_collector #(.FPFORMAT(FP16ALT), .N_ROWS(2), .LATENCY(2), .DEPTH(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear),
        .issue_valid_i(b_iv), .issue_strb_i(b_strb), .issue_ready_o(b_ir),
        .exp_res_i(b_xres), .valid_o(b_valid), .ready_i(b_ready),
        .res_o(b_res), .strb_o(b_strb_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [1:0]  strb;
        logic [31:0] xres;
        logic        rdy;
        logic        e_ir;
        logic        e_valid;
        logic [31:0] e_res;
        logic [1:0]  e_strb;
        logic [1:0]  e_cred;
    } vec_t;

    vec_t tbl [16];

    // Puts P, Q, R into u_b with ready low: P and Q land in the FIFO, R stays
    // in the first pipeline stage, credits are exhausted.
    task automatic fill_b();
        b_ready = 1'b0;
        b_iv = 1'b1; b_strb = 2'b01; b_xres = 32'h0;         step();
        b_iv = 1'b1; b_strb = 2'b10; b_xres = 32'h0;         step();
        b_iv = 1'b1; b_strb = 2'b11; b_xres = 32'h1111_0001; step();
        b_iv = 1'b0; b_strb = 2'b00; b_xres = 32'h2222_0002; step();
        check("fill_count", 32'(u_b.count_q), 32'd2);
        check("fill_credits", 32'(u_b.credits_q), 32'd0);
        check("fill_head", b_res, 32'h1111_0001);
    endtask

    task automatic check_b_cleared(input string tag);
        check({tag, "_valid"},   32'(b_valid), 32'd0);
        check({tag, "_res"},     b_res, 32'd0);
        check({tag, "_strb"},    32'(b_strb_o), 32'd0);
        check({tag, "_ir"},      32'(b_ir), 32'd1);
        check({tag, "_credits"}, 32'(u_b.credits_q), 32'd3);
        check({tag, "_wrpend"},  32'(u_b.wr_pending_q), 32'd0);
        check({tag, "_count"},   32'(u_b.count_q), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_q [$];

        //        iv    strb   xres          rdy | ir    valid  res           strb   cred
        tbl[0]  = '{1'b1, 2'b01, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 2'd2};
        tbl[1]  = '{1'b1, 2'b11, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 2'd1};
        tbl[2]  = '{1'b1, 2'b00, 32'hAAAA_1111, 1'b0, 1'b1, 1'b1, 32'hAAAA_1111, 2'b01, 2'd1};
        tbl[3]  = '{1'b1, 2'b00, 32'hBBBB_2222, 1'b0, 1'b1, 1'b1, 32'hAAAA_1111, 2'b01, 2'd1};
        tbl[4]  = '{1'b0, 2'b00, 32'hDEAD_DEAD, 1'b1, 1'b1, 1'b1, 32'hBBBB_2222, 2'b11, 2'd2};
        tbl[5]  = '{1'b0, 2'b00, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 2'd3};
        tbl[6]  = '{1'b1, 2'b10, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 2'd2};
        tbl[7]  = '{1'b1, 2'b01, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 2'd1};
        tbl[8]  = '{1'b1, 2'b11, 32'hCCCC_0003, 1'b0, 1'b0, 1'b1, 32'hCCCC_0003, 2'b10, 2'd0};
        tbl[9]  = '{1'b1, 2'b01, 32'hDDDD_0004, 1'b0, 1'b0, 1'b1, 32'hCCCC_0003, 2'b10, 2'd0};
        tbl[10] = '{1'b1, 2'b01, 32'h0,         1'b1, 1'b1, 1'b1, 32'hDDDD_0004, 2'b01, 2'd1};
        tbl[11] = '{1'b1, 2'b01, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 2'd1};
        tbl[12] = '{1'b1, 2'b00, 32'hEEEE_0005, 1'b0, 1'b1, 1'b1, 32'hEEEE_0005, 2'b11, 2'd1};
        tbl[13] = '{1'b1, 2'b00, 32'hFFFF_0006, 1'b0, 1'b1, 1'b1, 32'hEEEE_0005, 2'b11, 2'd1};
        tbl[14] = '{1'b0, 2'b00, 32'h0,         1'b1, 1'b1, 1'b1, 32'hFFFF_0006, 2'b01, 2'd2};
        tbl[15] = '{1'b0, 2'b00, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 2'd3};

        rst_n   = 1'b0;
        a_clear = 1'b0; a_iv = 1'b0; a_strb = 1'b0; a_xres = '0; a_ready = 1'b0;
        b_clear = 1'b0; b_iv = 1'b0; b_strb = 2'b0; b_xres = '0; b_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check("rst_a_ir", 32'(a_ir), 32'd1);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_res", 32'(a_res), 32'd0);
        check("rst_a_credits", 32'(u_a.credits_q), 32'd4);
        check_b_cleared("rst_b");

        // Vector table on u_b: in-order capture, bubble removal, credit stall,
        // simultaneous pop and issue at one credit.
        for (int i = 0; i < 16; i++) begin
            b_iv    = tbl[i].iv;
            b_strb  = tbl[i].strb;
            b_xres  = tbl[i].xres;
            b_ready = tbl[i].rdy;
            step();
            check($sformatf("vec%0d_ir", i),      32'(b_ir),          32'(tbl[i].e_ir));
            check($sformatf("vec%0d_valid", i),   32'(b_valid),       32'(tbl[i].e_valid));
            check($sformatf("vec%0d_res", i),     b_res,              tbl[i].e_res);
            check($sformatf("vec%0d_strb", i),    32'(b_strb_o),      32'(tbl[i].e_strb));
            check($sformatf("vec%0d_credits", i), 32'(u_b.credits_q), 32'(tbl[i].e_cred));
        end
        b_iv = 1'b0; b_strb = 2'b00; b_ready = 1'b0;

        // LATENCY=0: result written in the issue cycle itself
        a_iv = 1'b1; a_strb = 1'b1; a_xres = 16'h3F80; a_ready = 1'b0;
        step();
        check("l0_valid", 32'(a_valid), 32'd1);
        check("l0_res", 32'(a_res), 32'h3F80);
        check("l0_strb", 32'(a_strb_o), 32'd1);
        check("l0_credits", 32'(u_a.credits_q), 32'd3);
        a_iv = 1'b0; a_ready = 1'b1;
        step();
        check("l0_pop_valid", 32'(a_valid), 32'd0);
        check("l0_pop_credits", 32'(u_a.credits_q), 32'd4);

        // LATENCY=0 bubble: no credit, nothing stored
        a_iv = 1'b1; a_strb = 1'b0; a_xres = 16'h1234; a_ready = 1'b0;
        step();
        check("l0_bubble_valid", 32'(a_valid), 32'd0);
        check("l0_bubble_credits", 32'(u_a.credits_q), 32'd4);

        // Streaming at steady occupancy 3 with write and pop on the same edge,
        // 13 beats in total so both pointers wrap several times.
        for (int i = 0; i < 3; i++) begin
            a_iv = 1'b1; a_strb = 1'b1; a_xres = 16'h1000 + 16'(i); a_ready = 1'b0;
            step();
            exp_q.push_back(16'h1000 + 16'(i));
        end
        check("stream_fill_credits", 32'(u_a.credits_q), 32'd1);
        for (int i = 3; i < 13; i++) begin
            a_iv = 1'b1; a_strb = 1'b1; a_xres = 16'h1000 + 16'(i); a_ready = 1'b1;
            check($sformatf("stream%0d_head", i), 32'(a_res), 32'(exp_q[0]));
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(16'h1000 + 16'(i));
            check($sformatf("stream%0d_count", i), 32'(u_a.count_q), 32'd3);
            check($sformatf("stream%0d_credits", i), 32'(u_a.credits_q), 32'd1);
        end
        a_iv = 1'b0; a_strb = 1'b0; a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(a_valid), 32'd1);
            check($sformatf("drain%0d_head", i), 32'(a_res), 32'(exp_q[0]));
            step();
            void'(exp_q.pop_front());
        end
        check("drain_end_valid", 32'(a_valid), 32'd0);
        check("drain_end_credits", 32'(u_a.credits_q), 32'd4);
        a_ready = 1'b0;

        // Clear with two items stored and one in flight; clear wins over the
        // pop requested in the same cycle.
        fill_b();
        b_clear = 1'b1; b_iv = 1'b1; b_strb = 2'b11; b_ready = 1'b1;
        step();
        b_clear = 1'b0; b_iv = 1'b0; b_strb = 2'b00; b_ready = 1'b0;
        check_b_cleared("clr");
        // The dropped in-flight item must not reappear when bubbles drain.
        b_iv = 1'b1; b_strb = 2'b00; b_xres = 32'h5555_5555;
        step();
        step();
        b_iv = 1'b0;
        step();
        check("clr_drain_valid", 32'(b_valid), 32'd0);
        check("clr_drain_credits", 32'(u_b.credits_q), 32'd3);

        // Same situation, ended by reset instead
        fill_b();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_b_cleared("rstm");
        check("rstm_a_valid", 32'(a_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/expu_res_collector.md
Name: expu_res_collector

Overview:
- Receive side of the exponential-unit datapath. Captures per-row results from the row pipeline (`NUM_REGS` stages, stage registers advance only on an accepted issue) into a result FIFO.
- Re-associates each result with its row strobe and presents it downstream over a valid/ready interface.
- Provides credit-based back-pressure on the issue side, so a result emerging from the non-draining pipeline always has a FIFO slot.

Parameters:
FPFORMAT, fpnew_pkg::FP16ALT, element format; WIDTH = fp_width(FPFORMAT)
N_ROWS, 1, rows per beat
LATENCY, 0, register stages in the exp pipeline (equals its NUM_REGS)
DEPTH, 4, result FIFO entries; elaboration error if DEPTH < LATENCY+1

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
clear_i  in  1  synchronous clear, same effect as reset
issue_valid_i  in  1  issuer presents a beat to the exp unit
issue_strb_i  in  N_ROWS  row strobes of the issued beat
issue_ready_o  out  1  beat accepted; also drives the exp unit ready_i
exp_res_i  in  N_ROWS*WIDTH  exp unit res_o
valid_o  out  1  result beat available
ready_i  in  1  downstream accepts head beat
res_o  out  N_ROWS*WIDTH  head beat results
strb_o  out  N_ROWS  head beat row strobes

Behaviour:
- Reset/clear values:
  - issue_ready_o=1, credits=DEPTH.
  - valid_o=0, res_o=0, strb_o=0.
  - All tags invalid, wr_pending=0, FIFO empty.
  - clear_i has priority over every other event in the same cycle.
- Issue handshake:
  - issue_fire = issue_valid_i & issue_ready_o.
  - issue_ready_o = (credits != 0). It is a function of registers only; there is no combinational path from issue_valid_i or ready_i.
- Bubbles and credits:
  - A beat with issue_strb_i == 0 is a bubble. It consumes no credit and never enters the FIFO.
  - Bubbles exist to advance the exp pipeline so earlier items drain.
- Credit counter, width clog2(DEPTH+1):
  - Decrements on issue_fire with non-zero strb.
  - Increments on pop (valid_o & ready_i).
  - Both in the same cycle: unchanged.
  - Never exceeds DEPTH and never underflows; both are assertion-checked.
- Tag shift register, LATENCY>0:
  - Holds tags t[0..LATENCY-1], each {valid, strb}.
  - On issue_fire: t[0] <= {strb!=0, issue_strb_i} and t[i] <= t[i-1]. No shift otherwise.
  - On the same edge, wr_pending <= the valid bit of the tag being loaded into t[LATENCY-1].
  - This mirrors the exp pipeline, whose last stage loads on the same edge.
- FIFO write, LATENCY>0:
  - Occurs in any cycle with wr_pending=1, using data = exp_res_i and strb = t[LATENCY-1].strb.
  - wr_pending clears after the write unless the same edge reloads it through a new issue_fire.
  - Write latency is exactly 1 cycle after the issue edge that moved the item into the last stage.
- FIFO write, LATENCY=0: occurs in the issue_fire cycle itself, with data = exp_res_i (combinational from the exp unit) and strb = issue_strb_i.
- Items and drain: an item issued as beat k is written after beat k+LATENCY has been issued. The issuer must append LATENCY bubbles to drain.
- FIFO behaviour:
  - Fall-through: valid_o = !empty; res_o/strb_o show the head entry, or 0 when empty.
  - Pop on valid_o & ready_i.
  - Simultaneous write and pop on a full FIFO is legal; occupancy is unchanged.
  - A write can never occur while the FIFO is full without a pop, because credits guarantee space. Write-while-full is an assertion failure.
  - Pointers wrap modulo DEPTH; occupancy counter width is clog2(DEPTH+1).
- Ordering: beats leave strictly in issue order, bubbles removed.
- No deadlock: with DEPTH ≥ LATENCY+1, at least one credit-holding item is in the FIFO whenever credits are 0.

Test Plan:
- LATENCY=0, DEPTH=4: issue strb=1 with exp_res_i=0x3F80 → same cycle FIFO write; next cycle valid_o=1, res_o=0x3F80, strb_o=1. With ready_i=1 it pops and credits return to 4.
- LATENCY=2: issue A, B, bubble, bubble with distinct exp_res_i per stage → A captured 1 cycle after the 3rd issue edge, B 1 cycle after the 4th, in order. Bubbles never appear on valid_o.
- Credit stall, DEPTH=3, LATENCY=2: issue 3 non-bubble beats with ready_i=0 → issue_ready_o=0 after the 3rd. One pop → issue_ready_o=1 on the next cycle.
- Simultaneous pop and non-bubble issue at credits=1 → credits stay 1 and issue_ready_o stays 1.
- Full FIFO with simultaneous write and pop → occupancy unchanged, ordering preserved across pointer wrap (≥2·DEPTH beats).
- Assert clear_i with 2 items in the FIFO and 1 in flight → next cycle valid_o=0, credits=DEPTH, wr_pending=0. Same check for rst_ni=0 mid-stream.
